// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Arbitrates two write-back request channels (ALU and load unit) onto the
//   single register-file write port. It also tracks which registers are still
//   waiting for a write-back so the issue stage can detect source-operand
//   hazards.
//
// Optional feature (compile-time macro RF_WB_BYPASS_EN):
//   Defined     - a source register being written this cycle (WE3 & A3==rsN)
//                 raises fwdN_hit and is masked out of the hazard; the
//                 consumer takes WD3.
//   Not defined - fwd1_hit/fwd2_hit are tied to 0; a hazard lasts until the
//                 edge that clears the busy bit. The port list is the same.
//
// Handshake:
//   A channel transfers at a rising clk edge where its valid and ready are
//   both 1. Ready is combinational from the two valids and the priority
//   pointer; at most one ready is high per cycle, and neither is high while
//   rst is 0. Valid must not depend on ready.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   alu_valid/ready/addr/data ALU write-back channel
//   mem_valid/ready/addr/data load-unit write-back channel
//   issue_valid, issue_dst    mark a destination register as pending
//   rs1, rs2, hazard          source-operand hazard query
//   WE3, A3, WD3              register-file write port (registered)
//   busy                      per-register pending bits
//   fwd1_hit, fwd2_hit        bypass indicators for rs1 / rs2
// -----------------------------------------------------------------------------
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [2:0]  alu_addr,
    input  logic [18:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [2:0]  mem_addr,
    input  logic [18:0] mem_data,
    input  logic        issue_valid,
    input  logic [2:0]  issue_dst,
    input  logic [2:0]  rs1,
    input  logic [2:0]  rs2,
    output logic        hazard,
    output logic        WE3,
    output logic [2:0]  A3,
    output logic [18:0] WD3,
    output logic [7:0]  busy,
    output logic        fwd1_hit,
    output logic        fwd2_hit
);

    // last_grant_q: 0 = ALU granted last, 1 = load unit granted last.
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [2:0]  a3_q, a3_d;
    logic [18:0] wd3_q, wd3_d;
    logic [7:0]  busy_q, busy_d;

    logic        alu_xfer;
    logic        mem_xfer;
    logic [7:0]  set_mask;
    logic [7:0]  clr_mask;
    logic        m1;
    logic        m2;

    // Arbitration: the sole requester wins; on contention the channel not
    // granted last wins.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (rst) begin
            if (alu_valid && (!mem_valid || last_grant_q)) begin
                alu_ready = 1'b1;
            end else if (mem_valid) begin
                mem_ready = 1'b1;
            end
        end
    end

    assign alu_xfer = alu_valid & alu_ready;
    assign mem_xfer = mem_valid & mem_ready;

    always_comb begin
        last_grant_d = last_grant_q;
        a3_d         = a3_q;
        wd3_d        = wd3_q;
        we_d         = alu_xfer | mem_xfer;
        if (alu_xfer) begin
            a3_d         = alu_addr;
            wd3_d        = alu_data;
            last_grant_d = 1'b0;
        end else if (mem_xfer) begin
            a3_d         = mem_addr;
            wd3_d        = mem_data;
            last_grant_d = 1'b1;
        end
    end

    // Clear is applied before set, so a same-edge set and clear of one bit
    // leaves it set, while different bits both take effect.
    always_comb begin
        set_mask = 8'h00;
        clr_mask = 8'h00;
        if (issue_valid) begin
            set_mask[issue_dst] = 1'b1;
        end
        if (we_q) begin
            clr_mask[a3_q] = 1'b1;
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            a3_q         <= 3'd0;
            wd3_q        <= 19'd0;
            busy_q       <= 8'h00;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            a3_q         <= a3_d;
            wd3_q        <= wd3_d;
            busy_q       <= busy_d;
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign fwd1_hit = we_q & (a3_q == rs1);
    assign fwd2_hit = we_q & (a3_q == rs2);
    assign m1       = fwd1_hit;
    assign m2       = fwd2_hit;
`else
    assign fwd1_hit = 1'b0;
    assign fwd2_hit = 1'b0;
    assign m1       = 1'b0;
    assign m2       = 1'b0;
`endif

    assign hazard = (busy_q[rs1] & ~m1) | (busy_q[rs2] & ~m2);

    assign WE3  = we_q;
    assign A3   = a3_q;
    assign WD3  = wd3_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed bench for rf_wb_arbiter. Inputs change 1 ns after a rising edge;
// outputs are sampled 1 ns (or more) after a rising edge, well clear of it.
// Expected values are hand-derived constants per scenario.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_addr;
    logic [18:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [2:0]  mem_addr;
    logic [18:0] mem_data;
    logic        issue_valid;
    logic [2:0]  issue_dst;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        hazard;
    logic        WE3;
    logic [2:0]  A3;
    logic [18:0] WD3;
    logic [7:0]  busy;
    logic        fwd1_hit;
    logic        fwd2_hit;

    int n_vec;
    int n_err;

`ifdef RF_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    rf_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .issue_valid(issue_valid),
        .issue_dst  (issue_dst),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard     (hazard),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .busy       (busy),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        alu_valid = 1'b1; mem_valid = 1'b1;
        alu_addr = 3'd1; alu_data = 19'd1; mem_addr = 3'd2; mem_data = 19'd2;
        issue_valid = 1'b0; issue_dst = 3'd0; rs1 = 3'd0; rs2 = 3'd0;
        #12;
        n_vec++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL rst_we3 got=%b exp=0", WE3); end
        n_vec++; if (A3 !== 3'd0) begin n_err++; $display("FAIL rst_a3 got=%0d exp=0", A3); end
        n_vec++; if (WD3 !== 19'd0) begin n_err++; $display("FAIL rst_wd3 got=%0d exp=0", WD3); end
        n_vec++; if (busy !== 8'h00) begin n_err++; $display("FAIL rst_busy got=%h exp=00", busy); end
        n_vec++; if ({alu_ready, mem_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready got=%b exp=00", {alu_ready, mem_ready}); end
        step();
        n_vec++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL rst_hold_we3 got=%b exp=0", WE3); end
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    // Both channels request for 4 cycles: ALU, MEM, ALU, MEM with no bubble.
    task automatic test_back_to_back();
        logic [1:0] exp_rdy;
        logic [2:0] exp_a3;
        alu_valid = 1'b1; mem_valid = 1'b1;
        alu_addr = 3'd1; mem_addr = 3'd6;
        for (int k = 0; k < 4; k++) begin
            alu_data = 19'(100 + k);
            mem_data = 19'(200 + k);
            #1;
            exp_rdy = (k % 2 == 0) ? 2'b10 : 2'b01;
            n_vec++; if ({alu_ready, mem_ready} !== exp_rdy) begin n_err++; $display("FAIL b2b_grant%0d got=%b exp=%b", k, {alu_ready, mem_ready}, exp_rdy); end
            step();
            exp_a3 = (k % 2 == 0) ? 3'd1 : 3'd6;
            n_vec++; if (WE3 !== 1'b1) begin n_err++; $display("FAIL b2b_we3_%0d got=%b exp=1", k, WE3); end
            n_vec++; if (A3 !== exp_a3) begin n_err++; $display("FAIL b2b_a3_%0d got=%0d exp=%0d", k, A3, exp_a3); end
            n_vec++; if (WD3 !== ((k % 2 == 0) ? 19'(100 + k) : 19'(200 + k))) begin n_err++; $display("FAIL b2b_wd3_%0d got=%0d", k, WD3); end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        n_vec++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL idle_we3 got=%b exp=0", WE3); end
        n_vec++; if (A3 !== 3'd6) begin n_err++; $display("FAIL idle_a3_hold got=%0d exp=6", A3); end
        n_vec++; if (WD3 !== 19'd203) begin n_err++; $display("FAIL idle_wd3_hold got=%0d exp=203", WD3); end
        n_vec++; if (busy !== 8'h00) begin n_err++; $display("FAIL nonbusy_write got=%h exp=00", busy); end
    endtask

    task automatic test_hazard();
        issue_valid = 1'b1; issue_dst = 3'd5;
        step();
        issue_valid = 1'b0; rs1 = 3'd5; rs2 = 3'd0;
        #1;
        n_vec++; if (busy !== 8'h20) begin n_err++; $display("FAIL haz_busy got=%h exp=20", busy); end
        n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL haz_set got=%b exp=1", hazard); end
        mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 19'd20;
        #1;
        n_vec++; if ({alu_ready, mem_ready} !== 2'b01) begin n_err++; $display("FAIL haz_grant got=%b exp=01", {alu_ready, mem_ready}); end
        step();
        mem_valid = 1'b0;
        #1;
        n_vec++; if ({WE3, A3, WD3} !== {1'b1, 3'd5, 19'd20}) begin n_err++; $display("FAIL haz_commit got=%b/%0d/%0d exp=1/5/20", WE3, A3, WD3); end
        n_vec++; if (hazard !== ~BYP) begin n_err++; $display("FAIL haz_during_wb got=%b exp=%b", hazard, ~BYP); end
        n_vec++; if (fwd1_hit !== BYP) begin n_err++; $display("FAIL haz_fwd1 got=%b exp=%b", fwd1_hit, BYP); end
        step();
        n_vec++; if (busy !== 8'h00) begin n_err++; $display("FAIL haz_clear_busy got=%h exp=00", busy); end
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_clear got=%b exp=0", hazard); end
        rs1 = 3'd0;
    endtask

    task automatic test_set_clear();
        issue_valid = 1'b1; issue_dst = 3'd3;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 19'd7;
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_dst = 3'd3;
        #1;
        n_vec++; if ({WE3, A3} !== {1'b1, 3'd3}) begin n_err++; $display("FAIL sc_commit got=%b/%0d exp=1/3", WE3, A3); end
        step();
        issue_valid = 1'b0;
        n_vec++; if (busy !== 8'h08) begin n_err++; $display("FAIL sc_same_bit got=%h exp=08", busy); end
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 19'd9;
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_dst = 3'd4;
        step();
        issue_valid = 1'b0;
        n_vec++; if (busy !== 8'h10) begin n_err++; $display("FAIL sc_diff_bits got=%h exp=10", busy); end
        alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 19'd11;
        step();
        alu_valid = 1'b0;
        step();
        n_vec++; if (busy !== 8'h00) begin n_err++; $display("FAIL sc_cleanup got=%h exp=00", busy); end
    endtask

    task automatic test_bypass();
        issue_valid = 1'b1; issue_dst = 3'd7;
        step();
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 3'd7; mem_data = 19'd33;
        step();
        mem_valid = 1'b0;
        rs1 = 3'd0; rs2 = 3'd7;
        #1;
        n_vec++; if ({busy[7], WE3, A3} !== {1'b1, 1'b1, 3'd7}) begin n_err++; $display("FAIL byp_setup got=%b/%b/%0d exp=1/1/7", busy[7], WE3, A3); end
        n_vec++; if (fwd2_hit !== BYP) begin n_err++; $display("FAIL byp_fwd2 got=%b exp=%b", fwd2_hit, BYP); end
        n_vec++; if (fwd1_hit !== 1'b0) begin n_err++; $display("FAIL byp_fwd1 got=%b exp=0", fwd1_hit); end
        n_vec++; if (hazard !== ~BYP) begin n_err++; $display("FAIL byp_hazard got=%b exp=%b", hazard, ~BYP); end
        step();
        n_vec++; if ({busy, fwd2_hit, hazard} !== {8'h00, 1'b0, 1'b0}) begin n_err++; $display("FAIL byp_after got=%h/%b/%b exp=00/0/0", busy, fwd2_hit, hazard); end
        rs2 = 3'd0;
    endtask

    // ALU transfer (pointer -> ALU), then reset before the write commits.
    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 19'd5;
        issue_valid = 1'b1; issue_dst = 3'd2;
        step();
        alu_valid = 1'b0; issue_valid = 1'b0;
        n_vec++; if ({WE3, busy} !== {1'b1, 8'h04}) begin n_err++; $display("FAIL rm_pre got=%b/%h exp=1/04", WE3, busy); end
        rst = 1'b0;
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        n_vec++; if ({WE3, A3, WD3} !== {1'b0, 3'd0, 19'd0}) begin n_err++; $display("FAIL rm_async got=%b/%0d/%0d exp=0/0/0", WE3, A3, WD3); end
        n_vec++; if ({alu_ready, mem_ready} !== 2'b00) begin n_err++; $display("FAIL rm_ready got=%b exp=00", {alu_ready, mem_ready}); end
        step();
        n_vec++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL rm_no_pulse got=%b exp=0", WE3); end
        alu_addr = 3'd1; alu_data = 19'd77; mem_addr = 3'd6; mem_data = 19'd88;
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 8'h00) begin n_err++; $display("FAIL rm_busy got=%h exp=00", busy); end
        n_vec++; if ({alu_ready, mem_ready} !== 2'b10) begin n_err++; $display("FAIL rm_first_grant got=%b exp=10", {alu_ready, mem_ready}); end
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        n_vec++; if ({WE3, A3, WD3} !== {1'b1, 3'd1, 19'd77}) begin n_err++; $display("FAIL rm_resume got=%b/%0d/%0d exp=1/1/77", WE3, A3, WD3); end
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_back_to_back();
        test_hazard();
        test_set_clear();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
